// File: rtl/decade_counter_mod_ten.sv
// decade_counter_mod_ten
//
// Synchronous modulo-MODULUS up-counter with a T-style count enable.
// MODULUS defaults to 10 (a decade / BCD digit stage). The count is shown
// twice, in the way a T flip-flop chain read from its inverted outputs shows it:
//   Q_bar : count in true binary, 0..MODULUS-1
//   Q     : bitwise complement of the count (~Q_bar)
//
// Ports:
//   clock     in   1  rising-edge clock
//   preset    in   1  asynchronous active-high reset, count -> 0
//   clear     in   1  synchronous active-high clear, count -> 0
//   T         in   1  count enable
//   Q         out  4  ~count
//   Q_bar     out  4  count
//   carry_out out  1  (only when DECADE_CARRY_OUT_EN is defined) high while
//                     the count is at its last value and T is enabling a
//                     step. Feed it to the T input of the next-higher digit.
//
// Optional feature macro: DECADE_CARRY_OUT_EN (undefined by default).
//
// Priority at each rising edge: preset > clear > T.

module decade_counter_mod_ten #(
    parameter int MODULUS = 10
) (
    input  logic       clock,
    input  logic       preset,
    input  logic       clear,
    input  logic       T,
    output logic [3:0] Q,
    output logic [3:0] Q_bar
`ifdef DECADE_CARRY_OUT_EN
    ,
    output logic       carry_out
`endif
);

    // Last legal count value, sized to the register width.
    localparam logic [3:0] LAST = 4'(MODULUS - 1);

    logic [3:0] cnt;

    // ">=" rather than "==" lets an out-of-range count (for example after an
    // upset) return to 0 on the next enabled edge rather than run through
    // the illegal codes.
    always_ff @(posedge clock or posedge preset) begin
        if (preset) begin
            cnt <= 4'd0;
        end else if (clear) begin
            cnt <= 4'd0;
        end else if (T) begin
            if (cnt >= LAST) begin
                cnt <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign Q_bar = cnt;
    assign Q     = ~cnt;

`ifdef DECADE_CARRY_OUT_EN
    // Combinational, so the next stage sees it in the same cycle in which
    // this stage wraps.
    assign carry_out = (cnt == LAST) && T && !clear && !preset;
`endif

endmodule

// File: tb/tb_decade_counter_mod_ten.sv
// tb_decade_counter_mod_ten
//
// Directed bench for decade_counter_mod_ten (MODULUS = 10). Expected counts
// go into a queue as each edge's stimulus is set up. They are taken out and
// compared 1 time unit after that rising edge. When DECADE_CARRY_OUT_EN is
// defined, a second stage is cascaded through carry_out and the pair is run
// through 00..99 and back to 00.

module tb_decade_counter_mod_ten;

    logic       clock = 1'b1;
    logic       preset;
    logic       clear;
    logic       T;
    logic [3:0] Q;
    logic [3:0] Q_bar;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

`ifdef DECADE_CARRY_OUT_EN
    logic       carry_out;
    logic       carry_hi;
    logic [3:0] Q_hi;
    logic [3:0] Q_bar_hi;
    logic [3:0] hi_q[$];
`endif

    decade_counter_mod_ten #(.MODULUS(10)) dut (
        .clock     (clock),
        .preset    (preset),
        .clear     (clear),
        .T         (T),
        .Q         (Q),
        .Q_bar     (Q_bar)
`ifdef DECADE_CARRY_OUT_EN
        ,
        .carry_out (carry_out)
`endif
    );

`ifdef DECADE_CARRY_OUT_EN
    decade_counter_mod_ten #(.MODULUS(10)) u_hi (
        .clock     (clock),
        .preset    (preset),
        .clear     (clear),
        .T         (carry_out),
        .Q         (Q_hi),
        .Q_bar     (Q_bar_hi),
        .carry_out (carry_hi)
    );
`endif

    // Clock: period 20. The first rising edge is at t=20.
    always #10 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Wait for one rising edge, then compare Q_bar and Q with the next entry
    // in the expected queue.
    task automatic tick(input string tag);
        logic [3:0] e;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_q_bar"}, Q_bar, e);
            check({tag, "_q"}, Q, ~e);
        end
    endtask

    task automatic run_edges(input string tag, input int n, input int start);
        for (int i = 1; i <= n; i++) begin
            exp_q.push_back(4'((start + i) % 10));
            tick(tag);
        end
    endtask

    initial begin
        // Reset held from time 0.
        preset = 1'b1;
        clear  = 1'b0;
        T      = 1'b0;
        #5;
        check("preset_q_bar", Q_bar, 4'b0000);
        check("preset_q", Q, 4'b1111);
        #5;
        // t=10: release reset. The first counting edge is at t=20.
        preset = 1'b0;
        T      = 1'b1;

        // Count and wrap: 15 edges give 1..9,0,1..5.
        run_edges("count", 15, 0);
        // Continue through the second wrap to 4.
        run_edges("count2", 9, 5);

        // Hold at 4 for 3 edges.
        T = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'd4);
            tick("hold");
        end

        // Step to 7, then clear synchronously with T still high.
        T = 1'b1;
        run_edges("pre_clear", 3, 4);
        clear = 1'b1;
        #5;
        check("clear_not_early", Q_bar, 4'd7);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'd0);
            tick("clear");
        end
        clear = 1'b0;

        // Count to 6, then assert preset between edges.
        run_edges("pre_preset", 6, 0);
        preset = 1'b1;
        #1;
        check("async_preset_q_bar", Q_bar, 4'b0000);
        check("async_preset_q", Q, 4'b1111);
        exp_q.push_back(4'd0);
        tick("preset_hold");
        preset = 1'b0;
        run_edges("after_preset", 2, 0);

`ifdef DECADE_CARRY_OUT_EN
        // Reset both stages, then count 100 edges through the cascade.
        preset = 1'b1;
        #1;
        preset = 1'b0;
        check("cascade_reset_hi", Q_bar_hi, 4'd0);
        for (int i = 1; i <= 100; i++) begin
            check_bit("carry_out", carry_out, ((i - 1) % 10) == 9);
            exp_q.push_back(4'(i % 10));
            hi_q.push_back(4'((i / 10) % 10));
            tick("cascade_lo");
            if (hi_q.size() != 0) begin
                check("cascade_hi", Q_bar_hi, hi_q.pop_front());
            end
        end
        // Bring the low stage to 9 with T low: carry_out must stay low.
        run_edges("to_nine", 9, 0);
        T = 1'b0;
        #1;
        check_bit("carry_t_low", carry_out, 1'b0);
        T = 1'b1;
        #1;
        check_bit("carry_t_high", carry_out, 1'b1);
`endif

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decade_counter_mod_ten.md
Name: decade_counter_mod_ten

Overview:
- Synchronous mod-10 (decade) up-counter with a T-style count enable.
- The counter state is presented twice: on Q_bar in true binary (0..9), and on Q as its bitwise complement. This mirrors a T flip-flop chain in which the count is read from the inverted outputs.
- Used as a BCD digit stage or as a divide-by-10 prescaler; it cascades through the optional carry output.

Parameters:
- MODULUS, default 10: count length; counts 0..MODULUS-1 and then wraps. Legal range 2..16. Default is the decade behaviour.

Ports:
- clock  input  1  single clock; all state changes on its rising edge except preset.
- preset  input  1  asynchronous, active-high reset. Forces the count to 0, so Q=4'b1111 and Q_bar=4'b0000.
- clear  input  1  synchronous, active-high clear of the count to 0.
- T  input  1  count enable (toggle enable); active-high.
- Q  output  4  bitwise complement of the count (~Q_bar).
- Q_bar  output  4  current count in true binary, 0..MODULUS-1.

Behaviour:
- State: one 4-bit count register cnt. Q_bar=cnt and Q=~cnt are continuous assignments, so Q and Q_bar are always exact complements.
- Reset:
  - preset=1 asynchronously sets cnt=0 (Q_bar=0000, Q=1111) without waiting for a clock edge.
  - cnt holds 0 while preset is high.
  - Deassertion is sampled at the next rising edge.
- Priority at each rising edge of clock: preset > clear > T.
  - clear=1: cnt<=0, regardless of T.
  - clear=0, T=1: if cnt==MODULUS-1 then cnt<=0, else cnt<=cnt+1.
  - clear=0, T=0: cnt holds.
- Wrap: with the default MODULUS the sequence is 0,1,...,9,0. The count never reaches 10..15 in normal operation.
- Illegal-state recovery: if cnt is >= MODULUS (e.g. after an SEU), the next edge with T=1 or clear=1 loads 0.
- Latency: the count updates one clock edge after T is sampled. Outputs change only on the rising edge or on preset assertion.
- X handling: clear is don't-care while preset=1. After preset deasserts, clear and T must be known.
- No other outputs and no handshakes.

Optional Feature:
- Macro DECADE_CARRY_OUT_EN.
- Defined:
  - Adds output port carry_out (1 bit).
  - carry_out is combinational and high when cnt==MODULUS-1 && T==1 && clear==0 && preset==0.
  - It is used as the T input of the next-higher digit for cascading, so a two-stage chain counts 00..99.
- Not defined:
  - Port carry_out is absent.
  - All other behaviour is identical.

Test Plan:
- Preset: preset=1, T=0 from time 0, then released at t=10 with clear=0 and T=1 (clock period 20) -> during preset Q_bar=0000 and Q=1111. Q_bar=0000 is also forced asynchronously when preset asserts mid-count (e.g. at count 6) without waiting for a clock edge.
- Count and wrap: T=1 held for 15 rising edges -> Q_bar sequence 1,2,...,9,0,1,...,5, with Q=~Q_bar at every sample. The 9->0 wrap occurs on the 10th edge.
- Hold: T=0 for 3 edges at count 4 -> Q_bar stays 0100 and Q stays 1011.
- Synchronous clear: clear=1 with T=1 at count 7 -> Q_bar=0000 on that edge, not before it. Holding clear=1 with T=1 keeps Q_bar=0000.
- Carry out (with DECADE_CARRY_OUT_EN): two cascaded stages counting from 0 for 100 edges -> carry_out pulses at count 9 only while T=1. The combined value reads 99 and then wraps to 00 on edge 100.
